// File: rtl/light_pwm.sv
// light_pwm: EMA-smoothed, slew-limited, glitch-free LED PWM fed by 8-bit light-sensor samples.
// Optional hysteresis on target updates is built when LIGHTPWM_DEADBAND_EN is defined.
module light_pwm #(
    parameter int unsigned SHIFT    = 3,
    parameter int unsigned DIV      = 4,
    parameter int unsigned STEP     = 16,
    parameter bit          INVERT   = 1'b1,
    parameter int unsigned DEADBAND = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample,
    input  logic       sample_vld,
    output logic       pwm,
    output logic [7:0] duty,
    output logic       primed
);
    localparam int unsigned   AW       = 8 + SHIFT;
    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [7:0]    STEP_W   = 8'(STEP);
    localparam logic [7:0]    CNT_LAST = 8'd254;

    if (SHIFT < 1 || SHIFT > 6) begin : g_bad_shift
        $error("light_pwm: SHIFT must be in 1..6");
    end
    if (DIV < 1) begin : g_bad_div
        $error("light_pwm: DIV must be at least 1");
    end
    if (STEP < 1 || STEP > 255) begin : g_bad_step
        $error("light_pwm: STEP must be in 1..255");
    end
    if (DEADBAND > 255) begin : g_bad_deadband
        $error("light_pwm: DEADBAND must be in 0..255");
    end

    logic [AW-1:0] acc_q, acc_d;
    logic          primed_q, primed_d;
    logic          upd_q, upd_d;
    logic [7:0]    target_q, target_d;
    logic [7:0]    duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;

    logic [7:0]    filt;
    logic [7:0]    new_tgt;
    logic          tick;
    logic          boundary;
    logic [7:0]    up_diff;
    logic [7:0]    dn_diff;

`ifdef LIGHTPWM_DEADBAND_EN
    localparam logic [7:0] DB_W = 8'(DEADBAND);
    logic       loaded_q, loaded_d;
    logic [7:0] tgt_diff;
`endif

    assign filt = acc_q[AW-1:SHIFT];

    // acc - (acc >> SHIFT) + sample never exceeds the AW-bit range, so no wider sum is needed.
    always_comb begin
        acc_d    = acc_q;
        primed_d = primed_q;
        upd_d    = sample_vld;
        if (sample_vld) begin
            if (!primed_q) begin
                acc_d    = {sample, {SHIFT{1'b0}}};
                primed_d = 1'b1;
            end else begin
                acc_d = acc_q - AW'(filt) + AW'(sample);
            end
        end
    end

    always_comb begin
        new_tgt  = INVERT ? (8'd255 - filt) : filt;
        target_d = target_q;
`ifdef LIGHTPWM_DEADBAND_EN
        tgt_diff = (new_tgt > target_q) ? (new_tgt - target_q) : (target_q - new_tgt);
        loaded_d = loaded_q | upd_q;
        if (upd_q && (!loaded_q || tgt_diff > DB_W)) begin
            target_d = new_tgt;
        end
`else
        if (upd_q) begin
            target_d = new_tgt;
        end
`endif
    end

    always_comb begin
        tick     = (pre_q == PRE_LAST);
        boundary = tick && (cnt_q == CNT_LAST);
        pre_d    = tick ? '0 : (pre_q + PW'(1));
        cnt_d    = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : (cnt_q + 8'd1);
        end
    end

    // Slew toward target only at the period boundary so every period is drawn with one duty.
    always_comb begin
        duty_d  = duty_q;
        up_diff = target_q - duty_q;
        dn_diff = duty_q - target_q;
        if (boundary) begin
            if (!primed_q) begin
                duty_d = 8'd0;
            end else if (target_q > duty_q) begin
                duty_d = (up_diff > STEP_W) ? (duty_q + STEP_W) : target_q;
            end else if (target_q < duty_q) begin
                duty_d = (dn_diff > STEP_W) ? (duty_q - STEP_W) : target_q;
            end
        end
    end

    assign pwm_d = (cnt_q < duty_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            primed_q <= 1'b0;
            upd_q    <= 1'b0;
            target_q <= 8'd0;
            duty_q   <= 8'd0;
            pwm_q    <= 1'b0;
            cnt_q    <= 8'd0;
            pre_q    <= '0;
`ifdef LIGHTPWM_DEADBAND_EN
            loaded_q <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            primed_q <= primed_d;
            upd_q    <= upd_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
`ifdef LIGHTPWM_DEADBAND_EN
            loaded_q <= loaded_d;
`endif
        end
    end

    assign pwm    = pwm_q;
    assign duty   = duty_q;
    assign primed = primed_q;

endmodule

// File: tb/tb_light_pwm.sv
// tb_light_pwm: directed, self-checking bench for light_pwm using four differently
// parameterised instances sharing one sample stream (DIV=1 x3, DIV=4 x1).
module tb_light_pwm;

    typedef struct {
        logic [7:0] smp;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_c;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] sample;
    logic       sample_vld;

    logic       pwm_a, pwm_b, pwm_c, pwm_d;
    logic [7:0] duty_a, duty_b, duty_c, duty_d;
    logic       primed_a, primed_b, primed_c, primed_d;

    int edge_n;
    int n_total;
    int n_pass;

    vec_t vecs[6];

    light_pwm #(.SHIFT(3), .DIV(1), .STEP(16), .INVERT(1'b0), .DEADBAND(4)) u_a (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_vld(sample_vld),
        .pwm(pwm_a), .duty(duty_a), .primed(primed_a)
    );
    light_pwm #(.SHIFT(3), .DIV(1), .STEP(255), .INVERT(1'b0), .DEADBAND(4)) u_b (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_vld(sample_vld),
        .pwm(pwm_b), .duty(duty_b), .primed(primed_b)
    );
    light_pwm #(.SHIFT(3), .DIV(1), .STEP(255), .INVERT(1'b1), .DEADBAND(4)) u_c (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_vld(sample_vld),
        .pwm(pwm_c), .duty(duty_c), .primed(primed_c)
    );
    light_pwm #(.SHIFT(3), .DIV(4), .STEP(255), .INVERT(1'b0), .DEADBAND(4)) u_d (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_vld(sample_vld),
        .pwm(pwm_d), .duty(duty_d), .primed(primed_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: edge k is the k-th rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_n);
    endtask

    task automatic gotoEdge(input int k);
        while (edge_n < k) @(negedge clk);
    endtask

    // Strobes one sample from a negedge; returns at the negedge after the capturing edge.
    task automatic applyStimulus(input logic [7:0] smp);
        sample     = smp;
        sample_vld = 1'b1;
        @(negedge clk);
        sample_vld = 1'b0;
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        sample     = 8'd0;
        sample_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int idle_bad;
        int hi_a, hi_b, hi_c, hi_d;
        int m;

        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{smp: 8'd0,   exp_a: 8'd0,  exp_b: 8'd0,  exp_c: 8'd255};
        vecs[1] = '{smp: 8'd80,  exp_a: 8'd10, exp_b: 8'd10, exp_c: 8'd245};
        vecs[2] = '{smp: 8'd240, exp_a: 8'd26, exp_b: 8'd38, exp_c: 8'd217};
        vecs[3] = '{smp: 8'd240, exp_a: 8'd42, exp_b: 8'd64, exp_c: 8'd191};
        vecs[4] = '{smp: 8'd0,   exp_a: 8'd56, exp_b: 8'd56, exp_c: 8'd199};
        vecs[5] = '{smp: 8'd255, exp_a: 8'd72, exp_b: 8'd80, exp_c: 8'd175};

        // Reset state and three idle periods
        rst_n      = 1'b0;
        sample     = 8'd0;
        sample_vld = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_duty_c", duty_c, 0);
        checkOutput("reset_pwm_c", pwm_c, 0);
        checkOutput("reset_primed_a", primed_a, 0);
        rst_n = 1'b1;

        idle_bad = 0;
        for (int i = 0; i < 765; i++) begin
            @(negedge clk);
            if (pwm_a || pwm_b || pwm_c || pwm_d || primed_a || primed_b || primed_c || primed_d ||
                duty_a != 8'd0 || duty_b != 8'd0 || duty_c != 8'd0 || duty_d != 8'd0)
                idle_bad++;
        end
        checkOutput("idle_quiet", idle_bad, 0);

        // Single sample of 200, then slew ramp and PWM high counts
        gotoEdge(799);
        checkOutput("primed_before", primed_b, 0);
        applyStimulus(8'd200);
        checkOutput("primed_after", primed_b, 1);
        gotoEdge(1020);
        checkOutput("first_bnd_a", duty_a, 16);
        checkOutput("first_bnd_b", duty_b, 200);
        checkOutput("first_bnd_c", duty_c, 55);
        checkOutput("first_bnd_d", duty_d, 200);

        hi_a = 0; hi_b = 0; hi_c = 0; hi_d = 0;
        for (int e = 1021; e <= 4335; e++) begin
            @(negedge clk);
            if (e <= 1275) begin
                hi_a += int'(pwm_a);
                hi_b += int'(pwm_b);
                hi_c += int'(pwm_c);
            end
            if (e <= 2040) hi_d += int'(pwm_d);
            if (e % 255 == 0) begin
                m = e / 255;
                checkOutput("ramp_a", duty_a, (16 * (m - 3) > 200) ? 200 : 16 * (m - 3));
            end
        end
        checkOutput("pwm_high_a", hi_a, 16);
        checkOutput("pwm_high_b", hi_b, 200);
        checkOutput("pwm_high_c", hi_c, 55);
        checkOutput("pwm_high_d_div4", hi_d, 800);

        // Asynchronous reset in the middle of a period
        gotoEdge(4400);
        checkOutput("pre_rst_pwm_b", pwm_b, 1);
        checkOutput("pre_rst_duty_b", duty_b, 200);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pwm_b", pwm_b, 0);
        checkOutput("async_rst_duty_b", duty_b, 0);
        checkOutput("async_rst_primed_b", primed_b, 0);
        checkOutput("async_rst_duty_d", duty_d, 0);
        checkOutput("async_rst_duty_a", duty_a, 0);

        // Table: one sample mid-period, duties checked at the following boundary
        doReset();
        for (int i = 0; i < 6; i++) begin
            gotoEdge(255 * (i + 1) - 101);
            applyStimulus(vecs[i].smp);
            gotoEdge(255 * (i + 1));
            checkOutput($sformatf("vec%0d_a", i), duty_a, vecs[i].exp_a);
            checkOutput($sformatf("vec%0d_b", i), duty_b, vecs[i].exp_b);
            checkOutput($sformatf("vec%0d_c", i), duty_c, vecs[i].exp_c);
        end

        // Sample on the boundary cycle: boundary uses the old target
        gotoEdge(1784);
        applyStimulus(8'd240);
        checkOutput("bnd_sample_a", duty_a, 80);
        checkOutput("bnd_sample_b", duty_b, 80);
        checkOutput("bnd_sample_c", duty_c, 175);
        hi_b = 0;
        for (int e = 1786; e <= 2040; e++) begin
            @(negedge clk);
            hi_b += int'(pwm_b);
        end
        checkOutput("bnd_period_high_b", hi_b, 80);
        checkOutput("next_bnd_a", duty_a, 96);
        checkOutput("next_bnd_b", duty_b, 100);
        checkOutput("next_bnd_c", duty_c, 155);

        // INVERT extremes: dark gives constant high, then bright gives constant low
        doReset();
        gotoEdge(99);
        applyStimulus(8'd0);
        gotoEdge(255);
        checkOutput("dark_duty_c", duty_c, 255);
        checkOutput("dark_duty_b", duty_b, 0);
        hi_c = 0;
        sample = 8'd255;
        for (int e = 256; e <= 510; e++) begin
            sample_vld = (e >= 300 && e <= 419);
            @(negedge clk);
            hi_c += int'(pwm_c);
        end
        sample_vld = 1'b0;
        checkOutput("dark_high_c", hi_c, 255);
        checkOutput("bright_duty_a", duty_a, 16);
`ifndef LIGHTPWM_DEADBAND_EN
        checkOutput("bright_duty_c", duty_c, 0);
        checkOutput("bright_duty_b", duty_b, 255);
        hi_b = 0;
        hi_c = 0;
        for (int e = 511; e <= 765; e++) begin
            @(negedge clk);
            hi_b += int'(pwm_b);
            hi_c += int'(pwm_c);
        end
        checkOutput("bright_high_c", hi_c, 0);
        checkOutput("bright_high_b", hi_b, 255);
`endif

        // Small filter moves: held by deadband when enabled, followed otherwise
        doReset();
        gotoEdge(99);
        applyStimulus(8'd100);
        gotoEdge(255);
        checkOutput("db_first_b", duty_b, 100);
        gotoEdge(299);
        applyStimulus(8'd124);
        gotoEdge(510);
`ifdef LIGHTPWM_DEADBAND_EN
        checkOutput("db_small_b", duty_b, 100);
`else
        checkOutput("db_small_b", duty_b, 103);
`endif
        gotoEdge(559);
        applyStimulus(8'd119);
        gotoEdge(765);
        checkOutput("db_large_b", duty_b, 105);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
